mod_exp_engine: RTL and testbench

Parametrised, constant-time modular exponentiation engine computing `result = base^exponent mod modulus`. It uses left-to-right square-and-always-multiply over a shared bit-serial modular multiplier. It is the reusable successor to the fixed-mode exponentiation inside the RSA `control` datapath: operand width and exponent width are independent, a start/busy/done handshake is provided, and illegal operands are reported. It sits behind the key-generation/inverter stage and serves both encrypt and decrypt paths.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/mod_mult.sv | 86 ++++++++
 rtl/mod_exp_engine.sv | 157 +++++++++++++++
 tb/tb_mod_exp_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the modular exponentiation engine and its multiplier:
//   - state_t          : exponentiation FSM states
//   - MULT_EXTRA_BITS  : headroom bits of the multiplier's running remainder
//   - modexp_latency() : cycles from the accept edge to the done cycle
// -----------------------------------------------------------------------------
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SQR,
        ST_MUL,
        ST_DONE
    } state_t;

    // The remainder can reach 2r + b < 3n before reduction, so two bits of
    // headroom above the operand width are enough.
    localparam int MULT_EXTRA_BITS = 2;

    // One load cycle, then a square and a multiply per exponent bit (each
    // WIDTH+1 cycles), and the done cycle itself.
    function automatic int modexp_latency(input int width, input int exp_width);
        return 2 + 2 * exp_width * (width + 1);
    endfunction

endpackage

// File: rtl/mod_mult.sv
// -----------------------------------------------------------------------------
// mod_mult
// Bit-serial modular multiplier, p = a * b mod n, MSB-first interleaved
// shift-add over the bits of a. Requires a, b < n.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : one-cycle request; operands are sampled with it
//   a, b, n      : operands (WIDTH bits)
//   done         : high in the last of the WIDTH+1 cycles counted from start
//   p            : product, valid while done is high
// -----------------------------------------------------------------------------
module mod_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int RW = WIDTH + MULT_EXTRA_BITS;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [RW-1:0]    r_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;

    logic [RW-1:0]    n_ext;
    logic [RW-1:0]    sum;
    logic [RW-1:0]    red1;
    logic [RW-1:0]    red2;

    // One iteration: r = 2r + a_i*b, then two conditional subtractions bring
    // the result from below 3n back below n.
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally) so no latch is inferred.
    always_comb begin
        n_ext = RW'(n_q);
        sum   = (r_q << 1) + (a_q[WIDTH-1] ? RW'(b_q) : RW'(0));
        red1  = (sum  >= n_ext) ? sum  - n_ext : sum;
        red2  = (red1 >= n_ext) ? red1 - n_ext : red1;
    end

    // The final iteration result is presented combinationally so the caller
    // can capture it on the same edge that retires the last iteration.
    assign done = active_q && (cnt_q == CW'(1));
    assign p    = red2[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            // Setup cycle: latch operands, clear the remainder.
            a_q      <= a;
            b_q      <= b;
            n_q      <= n;
            r_q      <= '0;
            cnt_q    <= CW'(WIDTH);
            active_q <= 1'b1;
        end else if (active_q) begin
            a_q   <= a_q << 1;
            r_q   <= red2;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// -----------------------------------------------------------------------------
// mod_exp_engine
// Constant-time modular exponentiation, result = base^exponent mod modulus,
// left-to-right square-and-always-multiply over one shared mod_mult.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : request, accepted only when idle
//   base, modulus       : WIDTH-bit operands, latched on accept
//   exponent            : EXP_WIDTH-bit operand, latched on accept, scanned MSB first
//   busy                : high from the cycle after accept until done
//   done                : one-cycle pulse, result and error valid
//   result, error       : held until overwritten by the next completed job;
//                         error flags modulus < 2 or base >= modulus
// -----------------------------------------------------------------------------
module mod_exp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 error
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_t               state;
    state_t               next_state;

    logic [WIDTH-1:0]     base_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [WIDTH-1:0]     mod_q;
    logic [WIDTH-1:0]     acc_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 mult_go_q;

    logic                 operand_bad;
    logic                 exp_bit;
    logic [WIDTH-1:0]     mult_b;
    logic                 mult_done;
    logic [WIDTH-1:0]     mult_p;
    logic [WIDTH-1:0]     acc_after_mul;

    assign operand_bad   = (mod_q < WIDTH'(2)) || (base_q >= mod_q);
    assign exp_bit       = exp_q[idx_q];
    assign mult_b        = (state == ST_SQR) ? acc_q : base_q;
    // The multiply always runs; only the write-back depends on the key bit.
    assign acc_after_mul = exp_bit ? mult_p : acc_q;

    mod_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (mult_go_q),
        .a     (acc_q),
        .b     (mult_b),
        .n     (mod_q),
        .done  (mult_done),
        .p     (mult_p)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)      next_state = ST_LOAD;
            ST_LOAD: next_state = operand_bad ? ST_DONE : ST_SQR;
            ST_SQR:  if (mult_done)  next_state = ST_MUL;
            ST_MUL:  if (mult_done)  next_state = (idx_q == '0) ? ST_DONE : ST_SQR;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_LOAD, ST_SQR, ST_MUL: busy = 1'b1;
            ST_DONE:                 done = 1'b1;
            default: ;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            mult_go_q <= 1'b0;
            result    <= '0;
            error     <= 1'b0;
        end else begin
            // Kick the multiplier in the first cycle of every SQR and MUL so
            // each operation occupies exactly WIDTH+1 cycles.
            mult_go_q <= (next_state != state) &&
                         ((next_state == ST_SQR) || (next_state == ST_MUL));
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exponent;
                        mod_q  <= modulus;
                    end
                end
                ST_LOAD: begin
                    acc_q <= WIDTH'(1);
                    idx_q <= IDX_W'(EXP_WIDTH - 1);
                    if (operand_bad) begin
                        result <= '0;
                        error  <= 1'b1;
                    end
                end
                ST_SQR: begin
                    if (mult_done) begin
                        acc_q <= mult_p;
                    end
                end
                ST_MUL: begin
                    if (mult_done) begin
                        acc_q <= acc_after_mul;
                        if (idx_q == '0) begin
                            result <= acc_after_mul;
                            error  <= 1'b0;
                        end else begin
                            idx_q <= idx_q - IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_engine
// Directed bench for mod_exp_engine at WIDTH=16 and WIDTH=128. A plain
// arithmetic model (right-to-left binary exponentiation, extended Euclid)
// supplies expected values; one compare process checks the 16-bit instance
// every cycle.
// -----------------------------------------------------------------------------
module tb_mod_exp_engine;
    import rsa_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        start16 = 1'b0;
    logic [15:0] base16 = '0, exp16 = '0, mod16 = '0;
    logic        busy16, done16, error16;
    logic [15:0] result16;

    // 128-bit instance
    logic         start128 = 1'b0;
    logic [127:0] base128 = '0, exp128 = '0, mod128 = '0;
    logic         busy128, done128, error128;
    logic [127:0] result128;

    mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .base(base16),
        .exponent(exp16), .modulus(mod16), .busy(busy16), .done(done16),
        .result(result16), .error(error16)
    );

    mod_exp_engine #(.WIDTH(128), .EXP_WIDTH(128)) dut128 (
        .clk(clk), .reset(reset), .start(start128), .base(base128),
        .exponent(exp128), .modulus(mod128), .busy(busy128), .done(done128),
        .result(result128), .error(error128)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] ref_modexp(input logic [127:0] b, input logic [127:0] e,
                                                input logic [127:0] m, input int ew,
                                                output logic err);
        logic [255:0] r, x, n;
        err = (m < 128'd2) || (b >= m);
        if (err) return '0;
        n = 256'(m);
        r = 256'd1;
        x = 256'(b);
        for (int i = 0; i < ew; i++) begin
            if (e[i]) r = (r * x) % n;
            x = (x * x) % n;
        end
        return r[127:0];
    endfunction

    function automatic logic [255:0] ref_modinv(input logic [255:0] a, input logic [255:0] m);
        logic [255:0] r0, r1, t0, t1, q, rn, tn, tmp;
        r0 = m; r1 = a; t0 = '0; t1 = 256'd1;
        for (int k = 0; k < 1000 && r1 != 0; k++) begin
            q   = r0 / r1;
            rn  = r0 - q * r1;
            r0  = r1;
            r1  = rn;
            tmp = (q * t1) % m;
            tn  = (t0 >= tmp) ? t0 - tmp : t0 + m - tmp;
            t0  = t1;
            t1  = tn;
        end
        return t0;
    endfunction

    // ---------------- compare process (16-bit instance) ----------------
    bit          job_active = 0;
    int          cyc = 0;
    int          exp_len = 0;
    logic [15:0] exp_res = '0;
    logic        exp_err = 1'b0;
    int          last_done_cyc = 0;
    logic [15:0] last_res = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (job_active) begin
            check("busy16", busy16, 128'(cyc < exp_len));
            check("done16", done16, 128'(cyc == exp_len));
            if (cyc == exp_len) begin
                check("result16", result16, exp_res);
                check("error16", error16, exp_err);
                last_done_cyc = done16 ? cyc : -1;
                last_res      = result16;
                last_err      = error16;
                job_active    = 0;
            end else begin
                cyc++;
            end
        end else begin
            check("busy16_idle", busy16, 0);
            check("done16_idle", done16, 0);
        end
    end

    // Called at posedge+1 while the 16-bit engine is idle.
    task automatic job16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
        logic         err;
        logic [127:0] r;
        r       = ref_modexp(128'(b), 128'(e), 128'(m), 16, err);
        exp_res = r[15:0];
        exp_err = err;
        exp_len = err ? 2 : modexp_latency(16, 16);
        start16 = 1'b1;
        base16  = b;
        exp16   = e;
        mod16   = m;
        @(posedge clk);
        #1;
        start16    = 1'b0;
        cyc        = 1;
        job_active = 1;
    endtask

    task automatic wait16();
        for (int i = 0; i < 2000 && job_active; i++) @(posedge clk);
        check("job16_timeout", 128'(job_active), 0);
        job_active = 0;
        #1;
        check("result16_held", result16, exp_res);
    endtask

    task automatic job128(input logic [127:0] b, input logic [127:0] e, input logic [127:0] m,
                          output logic [127:0] res, output logic err, output int lat);
        int bound;
        bound    = modexp_latency(128, 128) + 10;
        start128 = 1'b1;
        base128  = b;
        exp128   = e;
        mod128   = m;
        @(posedge clk);
        #1;
        start128 = 1'b0;
        lat      = 1;
        res      = '0;
        err      = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done128) break;
            lat++;
        end
        res = result128;
        err = error128;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [255:0] p, q, n, phi, d;
        logic [127:0] msg, c_model, m_model, res;
        logic         err, merr;
        int           lat;

        #1 reset = 1'b1;
        #1;
        check("rst_busy", busy16, 0);
        check("rst_done", done16, 0);
        check("rst_result", result16, 0);
        check("rst_error", error16, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Main function, hand-computed values.
        job16(16'd4, 16'd13, 16'd497);
        wait16();
        check("lat_4_13", last_done_cyc, 546);
        check("res_4_13", last_res, 445);
        check("model_4_13", ref_modexp(128'd4, 128'd13, 128'd497, 16, merr), 445);

        job16(16'd3, 16'd0, 16'd7);
        wait16();
        check("lat_exp0", last_done_cyc, 546);
        check("res_exp0", last_res, 1);

        job16(16'd2, 16'd10, 16'd1000);
        wait16();
        check("res_2_10", last_res, 24);
        check("model_2_10", ref_modexp(128'd2, 128'd10, 128'd1000, 16, merr), 24);

        // Illegal operands.
        job16(16'd5, 16'd3, 16'd0);
        wait16();
        check("lat_mod0", last_done_cyc, 2);
        check("err_mod0", last_err, 1);
        check("res_mod0", last_res, 0);
        job16(16'd0, 16'd3, 16'd1);
        wait16();
        check("lat_mod1", last_done_cyc, 2);
        check("err_mod1", last_err, 1);
        job16(16'd500, 16'd3, 16'd497);
        wait16();
        check("lat_base_ge", last_done_cyc, 2);
        check("err_base_ge", last_err, 1);
        check("res_base_ge", last_res, 0);

        // Stray starts during SQR (cycle 4) and MUL (cycle 25) are ignored.
        job16(16'd4, 16'd13, 16'd497);
        repeat (3) @(posedge clk);
        #1;
        start16 = 1'b1; base16 = 16'd9; exp16 = 16'hffff; mod16 = 16'd1001;
        @(posedge clk);
        #1 start16 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start16 = 1'b1; base16 = 16'd7; exp16 = 16'd3; mod16 = 16'd11;
        @(posedge clk);
        #1 start16 = 1'b0;
        wait16();
        check("stray_res", last_res, 445);
        check("stray_lat", last_done_cyc, 546);

        // Reset in the middle of a MUL (cycle 25): async clear, no done.
        job16(16'd2, 16'd10, 16'd1000);
        repeat (24) @(posedge clk);
        #1 job_active = 0;
        #1 reset = 1'b1;
        #1;
        check("abort_busy", busy16, 0);
        check("abort_done", done16, 0);
        check("abort_result", result16, 0);
        check("abort_error", error16, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        job16(16'd3, 16'd5, 16'd7);
        wait16();
        check("after_abort_res", last_res, 5);

        // 128-bit RSA round trip.
        p   = 256'd8475698667747010771;
        q   = 256'd11297384090418420749;
        n   = p * q;
        phi = (p - 256'd1) * (q - 256'd1);
        d   = ref_modinv(256'd65537, phi);
        check("model_d_inverse", (d * 256'd65537) % phi, 1);
        msg     = 128'h4d0e3f77;
        c_model = ref_modexp(msg, 128'd65537, n[127:0], 128, merr);
        m_model = ref_modexp(c_model, d[127:0], n[127:0], 128, merr);
        check("model_roundtrip", m_model, 128'h4d0e3f77);

        job128(msg, 128'd65537, n[127:0], res, err, lat);
        check("enc_lat", lat, modexp_latency(128, 128));
        check("enc_res", res, c_model);
        check("enc_err", err, 0);

        job128(c_model, d[127:0], n[127:0], res, err, lat);
        check("dec_lat", lat, modexp_latency(128, 128));
        check("dec_res", res, m_model);
        check("dec_roundtrip", res, 128'h4d0e3f77);
        check("dec_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
